// File: rtl/fastmem_dsack.sv
// 68020 DSACK terminator for fast RAM (32-bit port) and autoconfig (8-bit port) cycles.
// Optional refresh starvation monitor enabled by defining FASTMEM_REFRESH_MON_EN.
module fastmem_dsack #(
    parameter int unsigned RAM_WAIT    = 2,
    parameter int unsigned WR_WAIT     = 1,
    parameter int unsigned Z2_WAIT     = 2,
    parameter int unsigned WAIT_W      = 3,
    parameter int unsigned REFRESH_MAX = 390,
    parameter int unsigned REF_W       = 9
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       RW20,
    input  logic       RAM_ACCESS,
    input  logic       Z2_ACCESS,
    output logic [1:0] DSACK,
    output logic       BUSY,
    output logic       REFRESH_LATE
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    if (RAM_WAIT >= (2 ** WAIT_W) || WR_WAIT >= (2 ** WAIT_W) || Z2_WAIT >= (2 ** WAIT_W)) begin : g_bad_wait
        $error("wait value does not fit WAIT_W");
    end
    if (REFRESH_MAX >= (2 ** REF_W)) begin : g_bad_ref
        $error("REFRESH_MAX does not fit REF_W");
    end

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_size32, w_size32_nxt;
    logic [1:0]        r_dsack, w_dsack_nxt;

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_size32 <= 1'b0;
            r_dsack  <= '1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_size32 <= w_size32_nxt;
            r_dsack  <= w_dsack_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_size32_nxt = r_size32;
        case (r_state)
            S_IDLE: begin
                if (!AS20) begin
                    // RAM select takes priority over autoconfig when both are low
                    if (!RAM_ACCESS) begin
                        w_cnt_nxt    = RW20 ? WAIT_W'(RAM_WAIT) : WAIT_W'(WR_WAIT);
                        w_size32_nxt = 1'b1;
                        w_state_nxt  = S_WAIT;
                    end else if (!Z2_ACCESS) begin
                        w_cnt_nxt    = WAIT_W'(Z2_WAIT);
                        w_size32_nxt = 1'b0;
                        w_state_nxt  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (AS20)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = S_ACK;
                else
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
            end
            S_ACK: begin
                if (AS20)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dsack_nxt = 2'b11;
        if (w_state_nxt == S_ACK)
            w_dsack_nxt = r_size32 ? 2'b00 : 2'b10;
        BUSY  = (r_state != S_IDLE);
        DSACK = r_dsack;
    end

`ifdef FASTMEM_REFRESH_MON_EN
    localparam logic [REF_W-1:0] REF_LIMIT = REF_W'(REFRESH_MAX);

    logic [REF_W-1:0] r_ref_cnt, w_ref_nxt;
    logic             r_late;

    // A read outside fast RAM leaves the DRAM idle for a CBR refresh
    always_comb begin
        w_ref_nxt = r_ref_cnt;
        if (!AS20 && RW20 && RAM_ACCESS)
            w_ref_nxt = '0;
        else if (r_ref_cnt != REF_LIMIT)
            w_ref_nxt = r_ref_cnt + REF_W'(1);
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            r_ref_cnt <= '0;
            r_late    <= 1'b0;
        end else begin
            r_ref_cnt <= w_ref_nxt;
            r_late    <= (w_ref_nxt == REF_LIMIT);
        end
    end

    assign REFRESH_LATE = r_late;
`else
    assign REFRESH_LATE = 1'b0;
`endif

endmodule

// File: tb/tb_fastmem_dsack.sv
// Directed bench for fastmem_dsack with a cycle-level transaction model and per-cycle compare.
module tb_fastmem_dsack;

    localparam int REF_LIM = 8;

    logic       clk = 1'b0;
    logic       RESET, AS20, RW20, RAM_ACCESS, Z2_ACCESS;
    logic [1:0] DSACK;
    logic       BUSY, REFRESH_LATE;

    int total = 0;
    int bad   = 0;

`ifdef FASTMEM_REFRESH_MON_EN
    localparam logic LATE_ON = 1'b1;
`else
    localparam logic LATE_ON = 1'b0;
`endif

    fastmem_dsack #(
        .RAM_WAIT(2), .WR_WAIT(1), .Z2_WAIT(2), .WAIT_W(3),
        .REFRESH_MAX(REF_LIM), .REF_W(9)
    ) dut (
        .CLKCPU(clk), .RESET(RESET), .AS20(AS20), .RW20(RW20),
        .RAM_ACCESS(RAM_ACCESS), .Z2_ACCESS(Z2_ACCESS),
        .DSACK(DSACK), .BUSY(BUSY), .REFRESH_LATE(REFRESH_LATE)
    );

    always #5 clk = ~clk;

    // Transaction model: a cycle starts at the accepting edge; DSACK falls wait+1 edges later.
    bit         m_active = 0, m_acked = 0, m_size32 = 0;
    int         m_wait = 0, m_elapsed = 0, m_since = 0;
    logic [1:0] exp_dsack = 2'b11;
    logic       exp_busy = 1'b0, exp_late = 1'b0;

    always @(posedge clk) begin
        if (RESET) begin
            m_active = 0; m_acked = 0; m_since = 0;
        end else begin
            if (!m_active) begin
                if (!AS20 && (!RAM_ACCESS || !Z2_ACCESS)) begin
                    m_active  = 1;
                    m_acked   = 0;
                    m_elapsed = 0;
                    m_size32  = !RAM_ACCESS;
                    m_wait    = !RAM_ACCESS ? (RW20 ? 2 : 1) : 2;
                end
            end else begin
                m_elapsed++;
                if (AS20) begin
                    m_active = 0; m_acked = 0;
                end else if (!m_acked && m_elapsed == m_wait + 1) begin
                    m_acked = 1;
                end
            end
            if (!AS20 && RW20 && RAM_ACCESS) m_since = 0;
            else m_since++;
        end
        exp_dsack = m_acked ? (m_size32 ? 2'b00 : 2'b10) : 2'b11;
        exp_busy  = m_active;
        exp_late  = LATE_ON && (m_since >= REF_LIM);
    end

    always @(posedge clk) begin
        #1;
        total++;
        if (DSACK !== exp_dsack || BUSY !== exp_busy || REFRESH_LATE !== exp_late) begin
            bad++;
            $display("FAIL model t=%0t dsack=%b/%b busy=%b/%b late=%b/%b (got/expected)",
                     $time, DSACK, exp_dsack, BUSY, exp_busy, REFRESH_LATE, exp_late);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    task automatic drive(input logic as, input logic rw, input logic ram, input logic z2);
        AS20 = as; RW20 = rw; RAM_ACCESS = ram; Z2_ACCESS = z2;
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, 1, 0, 1);
        tick(2);
        chk("reset_dsack", DSACK, 2'b11);
        chk("reset_busy", {1'b0, BUSY}, 2'b00);
        chk("reset_late", {1'b0, REFRESH_LATE}, 2'b00);
        RESET = 1'b0;
        drive(1, 1, 1, 1);
        tick(2);

        // fast RAM read, 2 waits
        drive(0, 1, 0, 1);
        tick(1); chk("rd_e0_busy", {1'b0, BUSY}, 2'b01);
        tick(2); chk("rd_e2", DSACK, 2'b11);
        tick(1); chk("rd_e3", DSACK, 2'b00);
        drive(1, 1, 1, 1);
        tick(1); chk("rd_rel", DSACK, 2'b11); chk("rd_rel_busy", {1'b0, BUSY}, 2'b00);
        tick(1);

        // fast RAM write, 1 wait; RW flip mid-cycle must not change timing
        drive(0, 0, 0, 1);
        tick(1); RW20 = 1'b1;
        tick(1); chk("wr_e1", DSACK, 2'b11);
        tick(1); chk("wr_e2", DSACK, 2'b00);
        drive(1, 1, 1, 1);
        tick(2);

        // autoconfig read, 8-bit port
        drive(0, 1, 1, 0);
        tick(3); chk("z2_e2", DSACK, 2'b11);
        tick(1); chk("z2_e3", DSACK, 2'b10);
        drive(1, 1, 1, 1);
        tick(2);

        // both selects low: RAM wins
        drive(0, 1, 0, 0);
        tick(4); chk("both_e3", DSACK, 2'b00);
        drive(1, 1, 1, 1);
        tick(2);

        // not our cycle
        drive(0, 1, 1, 1);
        tick(4); chk("foreign", {DSACK[1], BUSY}, 2'b10);
        drive(1, 1, 1, 1);
        tick(1);

        // abort during WAIT, then a normal cycle
        drive(0, 1, 0, 1);
        tick(2);
        drive(1, 1, 1, 1);
        tick(1); chk("abort_busy", {1'b0, BUSY}, 2'b00);
        tick(2); chk("abort_dsack", DSACK, 2'b11);
        drive(0, 1, 0, 1);
        tick(4); chk("post_abort", DSACK, 2'b00);
        tick(3); chk("hold_ack", DSACK, 2'b00);

        // reset while acknowledging releases DSACK at that edge
        RESET = 1'b1;
        tick(1); chk("rst_mid", DSACK, 2'b11);
        RESET = 1'b0;

        // refresh starvation: only RAM cycles after reset
        tick(7); chk("late_7", {1'b0, REFRESH_LATE}, 2'b00);
        tick(1); chk("late_8", {1'b0, REFRESH_LATE}, {1'b0, LATE_ON});
        RAM_ACCESS = 1'b1;
        tick(1); chk("late_clr", {1'b0, REFRESH_LATE}, 2'b00);
        drive(1, 1, 1, 1);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
